alu_seq_unit: RTL and testbench

Parametrised, registered ALU execution unit for the simplified MIPS datapath. It decodes the 2-bit ALUOp from the main control and the 6-bit R-type funct field internally. Single-cycle operations complete in one clock. Multi-cycle unsigned multiply (funct 110_000) and divide (funct 110_001) write a HI/LO pair. The unit sits in the execute stage behind a start/busy/done handshake, so the controller stalls only while a long operation runs.

---
 rtl/alu_seq_unit_if.sv | 32 +++
 rtl/alu_seq_unit.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_if.sv
// Execute-stage bus between the controller and alu_seq_unit.
// The controller drives operands and start; the unit returns results and handshake status.
interface alu_seq_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic [1:0]       alu_seq_opcode;
  logic [5:0]       alu_seq_funct;
  logic [SHW-1:0]   alu_seq_shamt;
  logic [WIDTH-1:0] alu_seq_a;
  logic [WIDTH-1:0] alu_seq_b;
  logic             alu_seq_start;
  logic [WIDTH-1:0] alu_seq_result;
  logic             alu_seq_zero;
  logic [WIDTH-1:0] alu_seq_hi;
  logic [WIDTH-1:0] alu_seq_lo;
  logic             alu_seq_busy;
  logic             alu_seq_done;
  logic             alu_seq_err;

  modport master (
    output alu_seq_opcode, alu_seq_funct, alu_seq_shamt, alu_seq_a, alu_seq_b, alu_seq_start,
    input  alu_seq_result, alu_seq_zero, alu_seq_hi, alu_seq_lo, alu_seq_busy, alu_seq_done,
           alu_seq_err
  );

  modport slave (
    input  alu_seq_opcode, alu_seq_funct, alu_seq_shamt, alu_seq_a, alu_seq_b, alu_seq_start,
    output alu_seq_result, alu_seq_zero, alu_seq_hi, alu_seq_lo, alu_seq_busy, alu_seq_done,
           alu_seq_err
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Registered MIPS execute-stage ALU: single-cycle ops plus iterative multu/divu
// producing a HI/LO pair, behind a start/busy/done handshake.
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_unit_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_UNS  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;

  localparam logic [SHW:0] CNT_END = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV
  } state_e;

  state_e             state_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SHW-1:0]     shamt_q;
  logic [SHW:0]       cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [3:0]         op_dec;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_err;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_rw;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_acc_d;

  always_comb begin
    op_dec = OP_UNS;
    case (bus.alu_seq_opcode)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        case (bus.alu_seq_funct)
          6'b100000: op_dec = OP_ADD;
          6'b100010: op_dec = OP_SUB;
          6'b100100: op_dec = OP_AND;
          6'b100101: op_dec = OP_OR;
          6'b100110: op_dec = OP_XOR;
          6'b101010: op_dec = OP_SLT;
          6'b000000: op_dec = OP_SLL;
          6'b000010: op_dec = OP_SRL;
          6'b110000: op_dec = OP_MULU;
          6'b110001: op_dec = OP_DIVU;
          default:   op_dec = OP_UNS;
        endcase
      end
      default: op_dec = OP_UNS;
    endcase
  end

  // Single-cycle datapath works on the operands latched at the start edge.
  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL:  exec_res = b_q << shamt_q;
      OP_SRL:  exec_res = b_q >> shamt_q;
      OP_DIVU: begin
        // Only a zero divisor reaches this path.
        exec_res = '1;
        exec_err = 1'b1;
      end
      default: begin
        exec_res = '0;
        exec_err = 1'b1;
      end
    endcase
  end

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Divide: acc holds {remainder, dividend bits not yet consumed / quotient bits}.
  always_comb begin
    div_rw   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rw - {1'b0, b_q};
    if (div_diff[WIDTH]) begin
      div_acc_d = {div_rw[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_UNS;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.alu_seq_start) begin
            op_q    <= op_dec;
            a_q     <= bus.alu_seq_a;
            b_q     <= bus.alu_seq_b;
            shamt_q <= bus.alu_seq_shamt;
            cnt_q   <= '0;
            if (op_dec == OP_MULU) begin
              acc_q   <= {{WIDTH{1'b0}}, bus.alu_seq_b};
              state_q <= S_MUL;
            end else if (op_dec == OP_DIVU && bus.alu_seq_b != '0) begin
              acc_q   <= {{WIDTH{1'b0}}, bus.alu_seq_a};
              state_q <= S_DIV;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result_q <= exec_res;
          zero_q   <= (exec_res == '0);
          err_q    <= exec_err;
          done_q   <= 1'b1;
          if (op_q == OP_DIVU) begin
            hi_q <= a_q;
            lo_q <= '1;
          end
          state_q <= S_IDLE;
        end
        S_MUL, S_DIV: begin
          // Last iteration runs at count WIDTH-1; the following edge commits.
          if (cnt_q == CNT_END) begin
            hi_q     <= acc_q[2*WIDTH-1:WIDTH];
            lo_q     <= acc_q[WIDTH-1:0];
            result_q <= acc_q[WIDTH-1:0];
            zero_q   <= (acc_q[WIDTH-1:0] == '0);
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            acc_q  <= (state_q == S_MUL) ? mul_acc_d : div_acc_d;
            cnt_q  <= cnt_q + CNT_ONE;
            busy_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_seq_result = result_q;
  assign bus.alu_seq_zero   = zero_q;
  assign bus.alu_seq_hi     = hi_q;
  assign bus.alu_seq_lo     = lo_q;
  assign bus.alu_seq_busy   = busy_q;
  assign bus.alu_seq_done   = done_q;
  assign bus.alu_seq_err    = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit: single-cycle ops, multu/divu timing,
// divide by zero, ignored start while busy, and asynchronous abort.
module tb_alu_seq_unit;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq_unit_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic drive(input logic [1:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_seq_opcode = opc;
    bus.alu_seq_funct  = fn;
    bus.alu_seq_shamt  = sh;
    bus.alu_seq_a      = a;
    bus.alu_seq_b      = b;
    bus.alu_seq_start  = 1'b1;
  endtask

  task automatic run_single(input string tag, input logic [1:0] opc, input logic [5:0] fn,
                            input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_err);
    drive(opc, fn, sh, a, b);
    @(posedge clk); #1;
    bus.alu_seq_start = 1'b0;
    check({tag, " done_low"}, {31'b0, bus.alu_seq_done}, 32'd0);
    @(posedge clk); #1;
    check({tag, " result"}, bus.alu_seq_result, exp_res);
    check({tag, " zero"}, {31'b0, bus.alu_seq_zero}, {31'b0, (exp_res == 32'd0)});
    check({tag, " err"}, {31'b0, bus.alu_seq_err}, {31'b0, exp_err});
    check({tag, " done"}, {31'b0, bus.alu_seq_done}, 32'd1);
  endtask

  task automatic run_multi(input string tag, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input bit interfere, input int abort_k);
    int busy_cnt = 0;
    int done_at  = 0;
    drive(2'b10, fn, 5'd0, a, b);
    @(posedge clk); #1;
    bus.alu_seq_start = 1'b0;
    check({tag, " busy_at_start"}, {31'b0, bus.alu_seq_busy}, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.alu_seq_busy) busy_cnt++;
      if (bus.alu_seq_done) begin
        done_at = k;
        break;
      end
      if (interfere && k == 9) drive(2'b10, 6'b100000, 5'd0, 32'd7, 32'd7);
      if (interfere && k == 10) bus.alu_seq_start = 1'b0;
      if (abort_k == k) begin
        #2 reset = 1'b1;
        #1;
        check({tag, " abort busy"}, {31'b0, bus.alu_seq_busy}, 32'd0);
        check({tag, " abort hi"}, bus.alu_seq_hi, 32'd0);
        check({tag, " abort lo"}, bus.alu_seq_lo, 32'd0);
        check({tag, " abort result"}, bus.alu_seq_result, 32'd0);
        check({tag, " abort zero"}, {31'b0, bus.alu_seq_zero}, 32'd1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check({tag, " post_abort busy"}, {31'b0, bus.alu_seq_busy}, 32'd0);
        check({tag, " post_abort done"}, {31'b0, bus.alu_seq_done}, 32'd0);
        return;
      end
    end
    check({tag, " done_cycle"}, done_at, 32'd33);
    check({tag, " busy_cycles"}, busy_cnt, 32'd32);
    check({tag, " busy_fall"}, {31'b0, bus.alu_seq_busy}, 32'd0);
    check({tag, " hi"}, bus.alu_seq_hi, exp_hi);
    check({tag, " lo"}, bus.alu_seq_lo, exp_lo);
    check({tag, " result"}, bus.alu_seq_result, exp_lo);
    check({tag, " err"}, {31'b0, bus.alu_seq_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alu_seq_opcode = 2'b00;
    bus.alu_seq_funct  = 6'd0;
    bus.alu_seq_shamt  = 5'd0;
    bus.alu_seq_a      = 32'd0;
    bus.alu_seq_b      = 32'd0;
    bus.alu_seq_start  = 1'b0;

    #3 reset = 1'b1;
    #1;
    check("reset result", bus.alu_seq_result, 32'd0);
    check("reset zero", {31'b0, bus.alu_seq_zero}, 32'd1);
    check("reset busy", {31'b0, bus.alu_seq_busy}, 32'd0);
    check("reset done", {31'b0, bus.alu_seq_done}, 32'd0);
    check("reset err", {31'b0, bus.alu_seq_err}, 32'd0);
    check("reset hi", bus.alu_seq_hi, 32'd0);
    check("reset lo", bus.alu_seq_lo, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_single("sub_eq", 2'b10, 6'b100010, 5'd0, 32'd5, 32'd5, 32'd0, 1'b0);
    check("sub_eq hi_hold", bus.alu_seq_hi, 32'd0);
    check("sub_eq lo_hold", bus.alu_seq_lo, 32'd0);
    run_single("slt_true", 2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    run_single("slt_false", 2'b10, 6'b101010, 5'd0, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_single("sll31", 2'b10, 6'b000000, 5'd31, 32'd0, 32'd1, 32'h8000_0000, 1'b0);
    run_single("srl4", 2'b10, 6'b000010, 5'd4, 32'd0, 32'hF000_0000, 32'h0F00_0000, 1'b0);
    run_single("xor", 2'b10, 6'b100110, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0);
    run_single("or", 2'b10, 6'b100101, 5'd0, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0);
    run_single("sub_branch", 2'b01, 6'b111111, 5'd0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    run_single("unsup_op", 2'b11, 6'b100000, 5'd0, 32'd1, 32'd2, 32'd0, 1'b1);
    run_single("unsup_fn", 2'b10, 6'b111111, 5'd0, 32'd1, 32'd2, 32'd0, 1'b1);

    run_multi("multu", 6'b110000, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b1, 0);
    run_single("and", 2'b10, 6'b100100, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    check("and hi_hold", bus.alu_seq_hi, 32'd1);
    check("and lo_hold", bus.alu_seq_lo, 32'hFFFF_FFFE);

    run_multi("divu", 6'b110001, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    run_single("divu_zero", 2'b10, 6'b110001, 5'd0, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
    check("divu_zero hi", bus.alu_seq_hi, 32'd100);
    check("divu_zero lo", bus.alu_seq_lo, 32'hFFFF_FFFF);
    check("divu_zero busy", {31'b0, bus.alu_seq_busy}, 32'd0);

    run_multi("multu_abort", 6'b110000, 32'd1234, 32'd5678, 32'd0, 32'd0, 1'b0, 15);
    run_single("add_after", 2'b00, 6'b000000, 5'd0, 32'd3, 32'd4, 32'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
